serial_digit_adder: RTL and testbench

//  Parametrised multi-cycle adder/subtractor; next generation of the 4-bit ripple adder.
//  One DIGIT-bit ripple slice is reused LSB-first over WIDTH/DIGIT cycles.

---
 rtl/sda_pkg.sv | 30 +++
 rtl/digit_adder.sv | 33 +++
 rtl/serial_digit_adder.sv | 126 ++++++++++++
 tb/tb_serial_digit_adder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sda_pkg.sv
// -----------------------------------------------------------------------------
// sda_pkg
// Shared types and helpers for the serial digit adder.
//   state_t : FSM encoding (IDLE, RUN, DONE)
//   clog2   : ceiling log2, used to size the digit counter
// -----------------------------------------------------------------------------
package sda_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DIGIT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// -----------------------------------------------------------------------------
// digit_adder
// Combinational DIGIT-bit ripple-carry adder slice.
//   i_a, i_b : DIGIT-bit addends
//   i_cin    : carry in
//   o_sum    : DIGIT-bit sum
//   o_cout   : carry out of the top bit
// -----------------------------------------------------------------------------
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_cin,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_cout
);

    logic [DIGIT:0] w_carry;

    always_comb begin
        w_carry    = '0;
        o_sum      = '0;
        w_carry[0] = i_cin;
        for (int i = 0; i < DIGIT; i++) begin
            o_sum[i]       = i_a[i] ^ i_b[i] ^ w_carry[i];
            w_carry[i + 1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_cout = w_carry[DIGIT];

endmodule

// File: rtl/serial_digit_adder.sv
// -----------------------------------------------------------------------------
// serial_digit_adder
// Multi-cycle adder/subtractor: one DIGIT-bit slice reused LSB-first over
// WIDTH/DIGIT cycles, with a start/busy/done handshake.
//   clk, rst_n     : clock, async active-low reset
//   start          : request, accepted when not busy
//   a, b, cin, sub : operands and mode, sampled with an accepted start
//   busy           : digits being processed
//   done           : one-cycle pulse, results valid
//   sum, cout, ovf : result, raw carry out, signed overflow
// -----------------------------------------------------------------------------
module serial_digit_adder
    import sda_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = clog2(NDIG) + 1;

    if (WIDTH % DIGIT != 0) begin : g_bad_param
        $error("serial_digit_adder: WIDTH must be a multiple of DIGIT");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic               w_accept;
    logic               w_last;
    logic [DIGIT-1:0]   w_s;
    logic               w_c;
    logic [WIDTH-1:0]   w_sum_shift;

    assign w_accept = start && (r_state != RUN);
    assign w_last   = (r_cnt == CNT_W'(NDIG - 1));

    // New digit enters at the MSB end; written so DIGIT==WIDTH needs no special case.
    logic [WIDTH+DIGIT-1:0] w_sum_cat;
    assign w_sum_cat   = {w_s, r_sum};
    assign w_sum_shift = w_sum_cat[WIDTH+DIGIT-1:DIGIT];

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_slice (
        .i_a    (r_a[DIGIT-1:0]),
        .i_b    (r_b[DIGIT-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_s),
        .o_cout (w_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = start ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            // Subtract as A + ~B + ~borrow_in.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? ~cin : cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_carry <= w_c;
            r_cnt   <= r_cnt + CNT_W'(1);
            r_sum   <= w_sum_shift;
            if (w_last) begin
                r_cout <= w_c;
                // On the last digit the operand MSBs sit at bit DIGIT-1.
                r_ovf  <= (r_a[DIGIT-1] == r_b[DIGIT-1]) && (w_s[DIGIT-1] != r_a[DIGIT-1]);
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Three instances (DIGIT = 1, 4, 16 at WIDTH = 16) checked against an
// arithmetic reference model.
module tb_serial_digit_adder;

    localparam int W      = 16;
    localparam int LAT_MAX = 19;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } res_t;

    logic          clk;
    logic          rst_n;
    logic [2:0]    start_v;
    logic [W-1:0]  tb_a;
    logic [W-1:0]  tb_b;
    logic          tb_cin;
    logic          tb_sub;
    wire  [2:0]    busy_v;
    wire  [2:0]    done_v;
    wire  [2:0]    cout_v;
    wire  [2:0]    ovf_v;
    wire  [W-1:0]  sum_v [3];

    int n_checks;
    int n_errors;
    int ndig [3] = '{16, 4, 1};
    int digs [3] = '{1, 4, 16};

    serial_digit_adder #(.WIDTH(W), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(tb_a), .b(tb_b), .cin(tb_cin),
        .sub(tb_sub), .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0]),
        .ovf(ovf_v[0])
    );
    serial_digit_adder #(.WIDTH(W), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(tb_a), .b(tb_b), .cin(tb_cin),
        .sub(tb_sub), .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1]),
        .ovf(ovf_v[1])
    );
    serial_digit_adder #(.WIDTH(W), .DIGIT(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(tb_a), .b(tb_b), .cin(tb_cin),
        .sub(tb_sub), .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .cout(cout_v[2]),
        .ovf(ovf_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer arithmetic, then reduce modulo 2^W.
    function automatic res_t model(input logic [W-1:0] va, input logic [W-1:0] vb,
                                   input logic vc, input logic vs);
        int   ua, ub, sa, sb, ci, t, r;
        res_t res;
        ua = {16'd0, va};
        ub = {16'd0, vb};
        sa = int'($signed(va));
        sb = int'($signed(vb));
        ci = {31'd0, vc};
        if (!vs) begin
            t      = ua + ub + ci;
            res.co = (t > 65535);
            r      = sa + sb + ci;
        end else begin
            t      = ua - ub - ci;
            res.co = (ua >= ub + ci);
            r      = sa - sb - ci;
        end
        res.s  = t[15:0];
        res.ov = (r > 32767) || (r < -32768);
        return res;
    endfunction

    task automatic drive_rand();
        tb_a   = 16'($urandom);
        tb_b   = 16'($urandom);
        tb_cin = 1'($urandom);
        tb_sub = 1'($urandom);
    endtask

    // Launch one op on the DUTs in mask; optionally pulse start again at cycle poke.
    task automatic run_op(input logic [2:0] mask, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vc, input logic vs, input int poke);
        res_t exp;
        int   dcnt [3];
        exp = model(va, vb, vc, vs);
        for (int i = 0; i < 3; i++) dcnt[i] = 0;
        @(negedge clk);
        tb_a    = va;
        tb_b    = vb;
        tb_cin  = vc;
        tb_sub  = vs;
        start_v = mask;
        for (int cyc = 1; cyc <= LAT_MAX; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start_v = 3'b000;
                drive_rand();
            end
            if (poke != 0 && cyc == poke) begin
                start_v = mask;
                drive_rand();
            end
            if (poke != 0 && cyc == poke + 1) start_v = 3'b000;
            for (int i = 0; i < 3; i++) begin
                if (mask[i] && done_v[i]) begin
                    dcnt[i]++;
                    check($sformatf("d%0d_latency", digs[i]), 32'(cyc), 32'(ndig[i] + 1));
                    check($sformatf("d%0d_sum", digs[i]), 32'(sum_v[i]), 32'(exp.s));
                    check($sformatf("d%0d_cout", digs[i]), 32'(cout_v[i]), 32'(exp.co));
                    check($sformatf("d%0d_ovf", digs[i]), 32'(ovf_v[i]), 32'(exp.ov));
                    check($sformatf("d%0d_busy_at_done", digs[i]), 32'(busy_v[i]), 32'd0);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (mask[i]) begin
                check($sformatf("d%0d_done_pulses", digs[i]), 32'(dcnt[i]), 32'd1);
                check($sformatf("d%0d_held_sum", digs[i]), 32'(sum_v[i]), 32'(exp.s));
            end
        end
    endtask

    initial begin
        res_t e1;
        res_t e2;
        int   pulses;
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        start_v  = 3'b000;
        tb_a     = '0;
        tb_b     = '0;
        tb_cin   = 1'b0;
        tb_sub   = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("d%0d_rst_busy", digs[i]), 32'(busy_v[i]), 32'd0);
            check($sformatf("d%0d_rst_done", digs[i]), 32'(done_v[i]), 32'd0);
            check($sformatf("d%0d_rst_sum", digs[i]), 32'(sum_v[i]), 32'd0);
            check($sformatf("d%0d_rst_cout", digs[i]), 32'(cout_v[i]), 32'd0);
            check($sformatf("d%0d_rst_ovf", digs[i]), 32'(ovf_v[i]), 32'd0);
        end
        rst_n = 1'b1;

        // Directed cases.
        run_op(3'b111, 16'h1234, 16'h1111, 1'b0, 1'b0, 0);
        run_op(3'b111, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(3'b111, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(3'b111, 16'h0000, 16'h0001, 1'b0, 1'b1, 0);
        run_op(3'b111, 16'h8000, 16'h0001, 1'b1, 1'b1, 0);

        // Start pulsed mid-RUN on the DIGIT=4 instance is ignored.
        run_op(3'b010, 16'h1234, 16'h1111, 1'b0, 1'b0, 2);

        // Start held into DONE: second op accepted back-to-back.
        e1 = model(16'hABCD, 16'h1357, 1'b1, 1'b0);
        e2 = model(16'h0F0F, 16'h7001, 1'b0, 1'b1);
        pulses = 0;
        @(negedge clk);
        tb_a = 16'hABCD; tb_b = 16'h1357; tb_cin = 1'b1; tb_sub = 1'b0;
        start_v = 3'b010;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start_v = 3'b000;
                drive_rand();
            end
            if (cyc == 4) begin
                tb_a = 16'h0F0F; tb_b = 16'h7001; tb_cin = 1'b0; tb_sub = 1'b1;
                start_v = 3'b010;
            end
            if (cyc == 6) begin
                start_v = 3'b000;
                check("b2b_busy_after_done", 32'(busy_v[1]), 32'd1);
            end
            if (done_v[1]) begin
                pulses++;
                if (pulses == 1) begin
                    check("b2b_first_cycle", 32'(cyc), 32'd5);
                    check("b2b_first_sum", 32'(sum_v[1]), 32'(e1.s));
                    check("b2b_first_cout", 32'(cout_v[1]), 32'(e1.co));
                end else begin
                    check("b2b_second_cycle", 32'(cyc), 32'd10);
                    check("b2b_second_sum", 32'(sum_v[1]), 32'(e2.s));
                    check("b2b_second_ovf", 32'(ovf_v[1]), 32'(e2.ov));
                end
            end
        end
        check("b2b_pulses", 32'(pulses), 32'd2);

        // Async reset during the second RUN cycle.
        @(negedge clk);
        tb_a = 16'h5A5A; tb_b = 16'h2121; tb_cin = 1'b1; tb_sub = 1'b0;
        start_v = 3'b011;
        @(negedge clk);
        start_v = 3'b000;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("d%0d_midrst_busy", digs[i]), 32'(busy_v[i]), 32'd0);
            check($sformatf("d%0d_midrst_done", digs[i]), 32'(done_v[i]), 32'd0);
            check($sformatf("d%0d_midrst_sum", digs[i]), 32'(sum_v[i]), 32'd0);
            check($sformatf("d%0d_midrst_cout", digs[i]), 32'(cout_v[i]), 32'd0);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int cyc = 0; cyc < LAT_MAX; cyc++) begin
            @(negedge clk);
            if (done_v[0] || done_v[1]) pulses++;
        end
        check("midrst_no_done", 32'(pulses), 32'd0);
        run_op(3'b111, 16'h4321, 16'h8765, 1'b1, 1'b0, 0);

        // Random regression across all three digit widths.
        for (int n = 0; n < 1000; n++) begin
            run_op(3'b111, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
